ex_eof: RTL
===========

EX_EOF -- requirements
Module: ExEof

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: `clock`, `reset` (asserted at 0).
REQ-002 SHALL expose ports (lane N = 0,1):
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `io_in_N_valid` in 1: lane N carries a completed execute result (driven by execute-stage writeEnable).
- `io_in_N_result` in 32: ALU result; for memory ops this is the address.
- `io_in_N_wdata` in 32: store data.
- `io_in_N_rd` in 5: destination register.
- `io_in_N_rdWen` in 1: rd is written.
- `io_in_N_isMem` in 1: memory op.
- `io_in_N_memOp` in 2: 01 load, 10 store.
- `io_alu_ready_out_N` out 1: lane N may present a result this cycle.
- `io_mem_req_valid` out 1, `io_mem_req_ready` in 1: memory request handshake.
- `io_mem_req_addr` out 32, `io_mem_req_wdata` out 32, `io_mem_req_memOp` out 2: memory request payload.
- `io_mem_resp_valid` in 1, `io_mem_resp_data` in 32: memory response.
- `io_wb_valid` out 1, `io_wb_rd` out 5, `io_wb_data` out 32: register-file write port.
- `io_retire_count` out 32: retired-entry counter.

Function
REQ-003 SHALL hold results in a 4-entry in-order FIFO (fields: result, wdata, rd, rdWen, isMem, memOp) with 3-bit occupancy count.
REQ-004 SHALL drive `io_alu_ready_out_0` = (free >= 1) and `io_alu_ready_out_1` = (free >= 2), with free computed from the registered count before this cycle's dequeue (no same-cycle bypass).
REQ-005 SHALL enqueue lane N when `in_N_valid` & `alu_ready_out_N`; when both lanes enqueue in one cycle, lane 0 SHALL occupy the older slot.
REQ-006 SHALL retire at most one entry per cycle, from the head only; enqueue and dequeue in the same cycle SHALL update the count by net change.
REQ-007 SHALL implement a two-state FSM: IDLE and WAIT_RESP.
REQ-008 IDLE, head non-mem: pop the head; if rdWen & rd!=0, register a writeback with data = result.
REQ-009 IDLE, head isMem: drive `io_mem_req_valid`=1 combinationally with head addr/wdata/memOp; on req_ready, go to WAIT_RESP; the head is not popped.
REQ-010 WAIT_RESP: `mem_req_valid`=0; on `io_mem_resp_valid`, pop the head, register a writeback (data = resp_data) if rdWen & rd!=0, and return to IDLE.
REQ-011 `io_mem_resp_valid` in IDLE SHALL be ignored.
REQ-012 Writeback outputs SHALL be registered: `io_wb_valid` pulses exactly one cycle, the cycle after the retire decision; otherwise `io_wb_valid`=0 and rd/data hold their last values.
REQ-013 `io_retire_count` SHALL increment by 1 per popped entry and wrap from 0xFFFFFFFF to 0.
REQ-014 Empty FIFO: no pop, `mem_req_valid`=0. Full FIFO: both readys 0. Head and tail pointers SHALL wrap modulo 4.

Reset
REQ-015 Reset asserted SHALL immediately clear count, pointers, FSM (to IDLE), `io_wb_valid`, `io_wb_rd`, `io_wb_data`, and `io_retire_count` to 0; resulting readys = 1/1 and `mem_req_valid` = 0.
REQ-016 Reset during WAIT_RESP SHALL discard the outstanding request; a late response SHALL be ignored (per REQ-011).

Structure
REQ-017 A shared package SHALL hold the entry struct, memOp encodings (LOAD=01, STORE=10), FIFO depth 4, and FSM state enum.
REQ-018 The FIFO storage and pointers SHALL be a sub-module `ExEofQueue` (2-in/1-out); the FSM, writeback and counter SHALL live in `ExEof`.

Verification
REQ-019 Lane0 only {result=0x10, rd=3, rdWen=1, isMem=0} into an empty block -> wb_valid=1, rd=3, data=0x10 one cycle later; retire_count=1.
REQ-020 Both lanes valid {rd=1, result=0xA} and {rd=2, result=0xB} -> writebacks rd1=0xA, then rd2=0xB on consecutive cycles.
REQ-021 Six back-to-back dual-lane pushes, no mem -> ready_1 drops when free<2, never more than 4 entries held, all six results written back in order.
REQ-022 Load at head {addr=0x100, rd=5}, req_ready held 0 for 3 cycles, then resp_data=0xDEAD two cycles after acceptance -> mem_req_valid held for 3 cycles with the head not popped, then a single wb rd=5 data=0xDEAD.
REQ-023 Store (rdWen=0) followed by an ALU op -> no writeback for the store; the ALU op retires only after the store's response.
REQ-024 Reset asserted in WAIT_RESP, then resp_valid after release -> FSM stays IDLE, no writeback, count=0, retire_count=0.

Source files
------------

// File: rtl/ex_eof_pkg.sv
// Shared types and constants for the execute-to-writeback (EX/EOF) retire stage.
package ex_eof_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        is_mem;
        logic [1:0]  mem_op;
    } entry_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/ex_eof_queue.sv
// Four-entry in-order result queue: two enqueue lanes, one dequeue from the head.
module ex_eof_queue
    import ex_eof_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push_0,
    input  entry_t           entry_0,
    input  logic             push_1,
    input  entry_t           entry_1,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] tail_next_slot;
    logic [PTR_W-1:0] lane1_slot;
    logic [PTR_W-1:0] push_num;
    logic             pop_ok;

    // Lane 1 lands behind lane 0 when both push; alone it takes the tail slot.
    always_comb begin
        tail_next_slot = tail_ptr + 2'd1;
        lane1_slot     = push_0 ? tail_next_slot : tail_ptr;
        push_num       = {1'b0, push_0} + {1'b0, push_1};
        pop_ok         = pop && (count != '0);
        head           = mem[head_ptr];
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push_0) mem[tail_ptr]   <= entry_0;
        if (push_1) mem[lane1_slot] <= entry_1;
    end

    // Pointers wrap naturally modulo 4; count moves by the net change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            tail_ptr <= tail_ptr + push_num;
            head_ptr <= head_ptr + {1'b0, pop_ok};
            count    <= count + {1'b0, push_num} - {2'b00, pop_ok};
        end
    end

endmodule

// File: rtl/ex_eof.sv
// Retire stage: queues execute results, issues memory ops in order, writes back.
module ex_eof
    import ex_eof_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_0_valid,
    input  logic [31:0] io_in_0_result,
    input  logic [31:0] io_in_0_wdata,
    input  logic [4:0]  io_in_0_rd,
    input  logic        io_in_0_rdWen,
    input  logic        io_in_0_isMem,
    input  logic [1:0]  io_in_0_memOp,
    input  logic        io_in_1_valid,
    input  logic [31:0] io_in_1_result,
    input  logic [31:0] io_in_1_wdata,
    input  logic [4:0]  io_in_1_rd,
    input  logic        io_in_1_rdWen,
    input  logic        io_in_1_isMem,
    input  logic [1:0]  io_in_1_memOp,
    output logic        io_alu_ready_out_0,
    output logic        io_alu_ready_out_1,
    output logic        io_mem_req_valid,
    input  logic        io_mem_req_ready,
    output logic [31:0] io_mem_req_addr,
    output logic [31:0] io_mem_req_wdata,
    output logic [1:0]  io_mem_req_memOp,
    input  logic        io_mem_resp_valid,
    input  logic [31:0] io_mem_resp_data,
    output logic        io_wb_valid,
    output logic [4:0]  io_wb_rd,
    output logic [31:0] io_wb_data,
    output logic [31:0] io_retire_count
);

    entry_t           entry_0;
    entry_t           entry_1;
    entry_t           head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic             push_0;
    logic             push_1;
    logic             pop;
    logic             wb_fire;
    logic [31:0]      wb_data_next;
    state_e           state;
    state_e           state_next;

    // Lane packing and readiness from the registered occupancy only.
    always_comb begin
        entry_0            = '{io_in_0_result, io_in_0_wdata, io_in_0_rd,
                               io_in_0_rdWen, io_in_0_isMem, io_in_0_memOp};
        entry_1            = '{io_in_1_result, io_in_1_wdata, io_in_1_rd,
                               io_in_1_rdWen, io_in_1_isMem, io_in_1_memOp};
        free               = CNT_W'(FIFO_DEPTH) - count;
        io_alu_ready_out_0 = (free >= 3'd1);
        io_alu_ready_out_1 = (free >= 3'd2);
        push_0             = io_in_0_valid && io_alu_ready_out_0;
        push_1             = io_in_1_valid && io_alu_ready_out_1;
    end

    ex_eof_queue u_queue (
        .clock   (clock),
        .reset   (reset),
        .push_0  (push_0),
        .entry_0 (entry_0),
        .push_1  (push_1),
        .entry_1 (entry_1),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Retire decision: pop/writeback for ALU heads, request/response for memory heads.
    always_comb begin
        state_next       = state;
        pop              = 1'b0;
        wb_fire          = 1'b0;
        wb_data_next     = head.result;
        io_mem_req_valid = 1'b0;
        io_mem_req_addr  = head.result;
        io_mem_req_wdata = head.wdata;
        io_mem_req_memOp = head.mem_op;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    if (!head.is_mem) begin
                        pop     = 1'b1;
                        wb_fire = head.rd_wen && (head.rd != 5'd0);
                    end else begin
                        io_mem_req_valid = 1'b1;
                        if (io_mem_req_ready) state_next = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (io_mem_resp_valid) begin
                    pop          = 1'b1;
                    wb_fire      = head.rd_wen && (head.rd != 5'd0);
                    wb_data_next = io_mem_resp_data;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered writeback port and wrapping retire counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_wb_valid     <= 1'b0;
            io_wb_rd        <= '0;
            io_wb_data      <= '0;
            io_retire_count <= '0;
        end else begin
            io_wb_valid <= wb_fire;
            if (wb_fire) begin
                io_wb_rd   <= head.rd;
                io_wb_data <= wb_data_next;
            end
            if (pop) io_retire_count <= io_retire_count + 32'd1;
        end
    end

endmodule
